// File: rtl/compare_tally.sv
// Tallies one-hot L/G/E results from magnitude_comparator, counts illegal codes,
// and flags runs of STREAK_N identical consecutive legal outcomes. STREAK_N must be >= 2.
module compare_tally #(
  parameter int CNT_W    = 8,
  parameter int STREAK_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             L,
  input  logic             G,
  input  logic             E,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       last_res,
  output logic             out_valid,
  output logic             code_err,
  output logic             streak_hit
);

  localparam int               RUN_W   = $clog2(STREAK_N) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STREAK_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshake: in_valid alone qualifies L/G/E; there is no ready, so every
  // cycle with in_valid=1 (and clear=0) is one accepted sample.

  logic [RUN_W-1:0] run, run_n;
  logic [CNT_W-1:0] cnt_lt_n, cnt_gt_n, cnt_eq_n, err_cnt_n;
  logic [1:0]       last_res_n, res_code;
  logic             out_valid_n, code_err_n, streak_hit_n, code_legal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    res_code   = 2'b00;
    code_legal = 1'b0;
    case ({L, G, E})
      3'b100:  begin res_code = 2'b01; code_legal = 1'b1; end
      3'b010:  begin res_code = 2'b10; code_legal = 1'b1; end
      3'b001:  begin res_code = 2'b11; code_legal = 1'b1; end
      default: begin res_code = 2'b00; code_legal = 1'b0; end
    endcase
  end

  always_comb begin
    cnt_lt_n     = cnt_lt;
    cnt_gt_n     = cnt_gt;
    cnt_eq_n     = cnt_eq;
    err_cnt_n    = err_cnt;
    last_res_n   = last_res;
    run_n        = run;
    streak_hit_n = streak_hit;
    out_valid_n  = 1'b0;
    code_err_n   = 1'b0;
    if (clear) begin
      // A sample coinciding with clear is dropped without any pulse.
      cnt_lt_n     = '0;
      cnt_gt_n     = '0;
      cnt_eq_n     = '0;
      err_cnt_n    = '0;
      last_res_n   = 2'b00;
      run_n        = '0;
      streak_hit_n = 1'b0;
    end else if (in_valid) begin
      out_valid_n = 1'b1;
      if (code_legal) begin
        case (res_code)
          2'b01:   cnt_lt_n = sat_inc(cnt_lt);
          2'b10:   cnt_gt_n = sat_inc(cnt_gt);
          default: cnt_eq_n = sat_inc(cnt_eq);
        endcase
        if (last_res != 2'b00 && res_code == last_res)
          run_n = (run >= RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
        else
          run_n = RUN_W'(1);
        last_res_n   = res_code;
        streak_hit_n = (run_n >= RUN_MAX);
      end else begin
        err_cnt_n    = sat_inc(err_cnt);
        code_err_n   = 1'b1;
        run_n        = '0;
        streak_hit_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_lt     <= '0;
      cnt_gt     <= '0;
      cnt_eq     <= '0;
      err_cnt    <= '0;
      last_res   <= 2'b00;
      run        <= '0;
      out_valid  <= 1'b0;
      code_err   <= 1'b0;
      streak_hit <= 1'b0;
    end else begin
      cnt_lt     <= cnt_lt_n;
      cnt_gt     <= cnt_gt_n;
      cnt_eq     <= cnt_eq_n;
      err_cnt    <= err_cnt_n;
      last_res   <= last_res_n;
      run        <= run_n;
      out_valid  <= out_valid_n;
      code_err   <= code_err_n;
      streak_hit <= streak_hit_n;
    end
  end

endmodule

// File: tb/tb_compare_tally.sv
// Bench for compare_tally: hand-written vector table, directed corner sequences,
// and a random phase, all checked through an expected-value queue.
module tb_compare_tally;

  localparam int CW = 4;
  localparam int SN = 3;

  typedef struct packed {
    logic [CW-1:0] lt, gt, eq, err;
    logic [1:0]    last;
    logic          ov, ce, sh;
  } out_t;
  localparam int OW = $bits(out_t);

  typedef struct {
    logic     iv;
    logic [2:0] lge;
    logic     clr;
    out_t     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, L, G, E, clear;
  logic [CW-1:0] cnt_lt, cnt_gt, cnt_eq, err_cnt;
  logic [1:0] last_res;
  logic out_valid, code_err, streak_hit;
  out_t dut_o;

  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_lt, m_gt, m_eq, m_err, m_last, m_run;
  logic m_ov, m_ce, m_sh;

  always #5 clk = ~clk;

  compare_tally #(.CNT_W(CW), .STREAK_N(SN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .L(L), .G(G), .E(E),
    .clear(clear), .cnt_lt(cnt_lt), .cnt_gt(cnt_gt), .cnt_eq(cnt_eq),
    .err_cnt(err_cnt), .last_res(last_res), .out_valid(out_valid),
    .code_err(code_err), .streak_hit(streak_hit)
  );

  assign dut_o = {cnt_lt, cnt_gt, cnt_eq, err_cnt, last_res, out_valid, code_err, streak_hit};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic model(input logic r, input logic iv, input logic [2:0] lge, input logic clr);
    int code;
    m_ov = 1'b0;
    m_ce = 1'b0;
    if (!r) begin
      m_lt = 0; m_gt = 0; m_eq = 0; m_err = 0; m_last = 0; m_run = 0; m_sh = 1'b0;
    end else if (clr) begin
      m_lt = 0; m_gt = 0; m_eq = 0; m_err = 0; m_last = 0; m_run = 0; m_sh = 1'b0;
    end else if (iv) begin
      m_ov = 1'b1;
      code = (lge == 3'b100) ? 1 : (lge == 3'b010) ? 2 : (lge == 3'b001) ? 3 : 0;
      if (code == 0) begin
        m_err = sat(m_err); m_ce = 1'b1; m_run = 0; m_sh = 1'b0;
      end else begin
        if (code == 1) m_lt = sat(m_lt);
        if (code == 2) m_gt = sat(m_gt);
        if (code == 3) m_eq = sat(m_eq);
        m_run = (m_last != 0 && code == m_last) ? ((m_run + 1 > SN) ? SN : m_run + 1) : 1;
        m_last = code;
        m_sh = (m_run >= SN);
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    o.lt = CW'(m_lt); o.gt = CW'(m_gt); o.eq = CW'(m_eq); o.err = CW'(m_err);
    o.last = 2'(m_last); o.ov = m_ov; o.ce = m_ce; o.sh = m_sh;
    return o;
  endfunction

  // Drive one cycle, predict, clock, then compare away from the edge.
  task automatic step(input logic r, input logic iv, input logic [2:0] lge, input logic clr);
    logic [OW-1:0] e;
    rst_n = r; in_valid = iv; {L, G, E} = lge; clear = clr;
    model(r, iv, lge, clr);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb", 32'(dut_o), 32'(e));
  endtask

  vec_t tbl[8];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; {L, G, E} = 3'b000; clear = 1'b0;
    m_lt = 0; m_gt = 0; m_eq = 0; m_err = 0; m_last = 0; m_run = 0;
    m_ov = 1'b0; m_ce = 1'b0; m_sh = 1'b0;

    // reset state
    step(1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 3'b100, 1'b1);
    chk("reset_state", 32'(dut_o), 32'(0));

    // L, G, E back to back; then two illegal codes and an E restarting the run
    tbl[0] = '{1'b1, 3'b100, 1'b0, out_t'{4'd1, 4'd0, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{1'b1, 3'b010, 1'b0, out_t'{4'd1, 4'd1, 4'd0, 4'd0, 2'b10, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{1'b1, 3'b001, 1'b0, out_t'{4'd1, 4'd1, 4'd1, 4'd0, 2'b11, 1'b1, 1'b0, 1'b0}};
    tbl[3] = '{1'b0, 3'b000, 1'b0, out_t'{4'd1, 4'd1, 4'd1, 4'd0, 2'b11, 1'b0, 1'b0, 1'b0}};
    tbl[4] = '{1'b1, 3'b000, 1'b0, out_t'{4'd1, 4'd1, 4'd1, 4'd1, 2'b11, 1'b1, 1'b1, 1'b0}};
    tbl[5] = '{1'b1, 3'b110, 1'b0, out_t'{4'd1, 4'd1, 4'd1, 4'd2, 2'b11, 1'b1, 1'b1, 1'b0}};
    tbl[6] = '{1'b1, 3'b001, 1'b0, out_t'{4'd1, 4'd1, 4'd2, 4'd2, 2'b11, 1'b1, 1'b0, 1'b0}};
    tbl[7] = '{1'b0, 3'b000, 1'b0, out_t'{4'd1, 4'd1, 4'd2, 4'd2, 2'b11, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].iv, tbl[i].lge, tbl[i].clr);
      chk($sformatf("tbl%0d", i), 32'(dut_o), 32'(tbl[i].exp));
    end

    // a single E after the illegal codes must not have raised a streak
    step(1'b1, 1'b1, 3'b001, 1'b0);
    chk("run_restart_no_hit", 32'(streak_hit), 32'(0));

    // four E samples with 2 idle cycles between them
    step(1'b1, 1'b0, 3'b000, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 3'b001, 1'b0);
      chk($sformatf("streak_e%0d", i), 32'(streak_hit), (i >= 3) ? 32'd1 : 32'd0);
      if (i < 4) begin
        step(1'b1, 1'b0, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'b000, 1'b0);
      end
    end
    chk("streak_cnt_eq", 32'(cnt_eq), 32'd4);
    step(1'b1, 1'b1, 3'b010, 1'b0);
    chk("streak_break_sh", 32'(streak_hit), 32'd0);
    chk("streak_break_last", 32'(last_res), 32'b10);

    // 17 L samples saturate a 4-bit tally at 15
    step(1'b1, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 3'b100, 1'b0);
    chk("sat_lt", 32'(cnt_lt), 32'd15);
    chk("sat_gt_eq", 32'({cnt_gt, cnt_eq}), 32'd0);
    step(1'b1, 1'b0, 3'b000, 1'b0);
    chk("sat_hold", 32'(cnt_lt), 32'd15);

    // clear colliding with a sample discards the sample
    step(1'b1, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b100, 1'b0);
    chk("pre_clear_lt", 32'(cnt_lt), 32'd5);
    step(1'b1, 1'b1, 3'b100, 1'b1);
    chk("clear_state", 32'({cnt_lt, last_res, out_valid, code_err}), 32'd0);
    step(1'b1, 1'b1, 3'b100, 1'b0);
    chk("post_clear_lt", 32'({cnt_lt, last_res, out_valid}), {25'd0, 4'd1, 2'b01, 1'b1});

    // reset mid-stream with streak active
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b001, 1'b0);
    chk("pre_rst_sh", 32'(streak_hit), 32'd1);
    step(1'b0, 1'b1, 3'b001, 1'b0);
    chk("midrst_state", 32'(dut_o), 32'd0);
    for (int i = 1; i <= SN; i++) begin
      step(1'b1, 1'b1, 3'b001, 1'b0);
      chk($sformatf("rst_streak_e%0d", i), 32'(streak_hit), (i == SN) ? 32'd1 : 32'd0);
    end

    // random stimulus, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      logic [2:0] lge;
      lge = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                        : (3'b100 >> $urandom_range(0, 2));
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), lge,
           ($urandom_range(0, 40) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/compare_tally.md
Name: compare_tally

Overview:
- Sequential stage directly downstream of `magnitude_comparator`; consumes its one-hot L/G/E result on a valid strobe.
- Keeps saturating tallies of less/greater/equal outcomes and flags illegal (non-one-hot) result codes.
- Detects runs of identical consecutive outcomes.
- Results feed lab-board LEDs/7-seg display logic and test benches.

Parameters:
- CNT_W, 8, width of each tally counter (saturating).
- STREAK_N, 3, number of consecutive identical legal outcomes that raises streak_hit; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  high for one cycle per comparator result to be sampled.
- L  input  1  comparator "A less than B".
- G  input  1  comparator "A greater than B".
- E  input  1  comparator "A equal to B".
- clear  input  1  synchronous clear of tallies/streak/last result.
- cnt_lt  output  CNT_W  number of accepted L outcomes.
- cnt_gt  output  CNT_W  number of accepted G outcomes.
- cnt_eq  output  CNT_W  number of accepted E outcomes.
- err_cnt  output  CNT_W  number of illegal codes sampled.
- last_res  output  2  last legal outcome: 00 none, 01 L, 10 G, 11 E.
- out_valid  output  1  one-cycle pulse, cycle after any sampled in_valid.
- code_err  output  1  one-cycle pulse, cycle after an illegal code was sampled.
- streak_hit  output  1  level, high while current run length >= STREAK_N.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). Reset has priority over all other inputs.
- Reset values: all counters 0, last_res=00, out_valid=0, code_err=0, streak_hit=0, internal run counter 0.
- Sampling occurs only on a rising edge with in_valid=1; inputs are ignored otherwise. No back-pressure: a sample is accepted every cycle in_valid is high.
- Legal code: exactly one of {L,G,E} high. Illegal codes: 000, 011, 101, 110, 111.
- Latency: all outputs are registered; every effect of a sample is visible one cycle after the sampling edge.
- Legal sample handling:
  - Matching tally increments by 1, saturating at 2^CNT_W-1 with no wrap.
  - last_res is updated.
  - out_valid pulses.
- Illegal sample handling:
  - err_cnt increments (saturating).
  - code_err and out_valid pulse.
  - cnt_lt/cnt_gt/cnt_eq and last_res are unchanged.
  - Run counter forced to 0, so streak_hit drops.
- Run counter (internal, width clog2(STREAK_N)+1):
  - Legal sample equal to last_res (last_res != 00): run = min(run+1, STREAK_N).
  - Legal sample different from last_res, or last_res = 00: run = 1.
  - streak_hit = (run >= STREAK_N), registered.
  - Cycles with in_valid=0 do not break a run.
- clear=1:
  - Zeroes all four counters, last_res, and run; streak_hit goes low the next cycle.
  - Any in_valid sample in the same cycle is discarded entirely: no count, no out_valid, no code_err.
- Pulse outputs (out_valid, code_err) are high for exactly one cycle per sample, including back-to-back samples (stays high on consecutive cycles).
- Reset asserted mid-stream: the next cycle shows reset values regardless of in_valid or clear.

Test Plan:
1. Reset, then three samples with in_valid on consecutive cycles: LGE=100 (A=0000,B=1101), 010 (A=0101,B=0100), 001 (A=1010,B=1010) -> cnt_lt=1, cnt_gt=1, cnt_eq=1, last_res=11, out_valid high 3 cycles, streak_hit=0, err_cnt=0.
2. Four consecutive E samples with idle gaps of 2 cycles between them -> streak_hit rises one cycle after the 3rd sample, stays high after the 4th; cnt_eq=4. Then a G sample -> streak_hit=0, last_res=10.
3. Sample LGE=000, then 110 -> code_err pulses twice, err_cnt=2, all other tallies and last_res unchanged; a following E sample restarts run at 1.
4. CNT_W=4: 17 L samples -> cnt_lt saturates at 15 and holds; cnt_gt=cnt_eq=0.
5. clear asserted in the same cycle as an L sample with cnt_lt=5 -> next cycle cnt_lt=0, last_res=00, out_valid=0; in_valid without clear then counts normally.
6. rst_n low for one cycle during a back-to-back E stream with streak_hit=1 -> all outputs at reset values next cycle; streak_hit needs STREAK_N new E samples to reassert.
